// File: rtl/bcd2bin_pkg.sv
// bcd2bin_pkg: shared constants, FSM state type and limits for the
// sign-magnitude BCD to two's-complement binary converter.
// Optional build macro used by bcd2bin: BCD2BIN_SAT_EN (saturate on overflow).
package bcd2bin_pkg;

    localparam int ND    = 4;                    // BCD digits
    localparam int BIN_W = 11;                   // two's-complement result width
    localparam int MAG_W = 14;                   // shift steps / magnitude width
    localparam int BCD_W = 4*ND+1;               // sign + digits
    localparam int CNT_W = $clog2(MAG_W+1);

    localparam logic [MAG_W-1:0] BIN_MAX_POS = MAG_W'(1023);
    localparam logic [MAG_W-1:0] BIN_MAX_NEG = MAG_W'(1024);

    localparam logic [BIN_W-1:0] SAT_POS = {1'b0, {(BIN_W-1){1'b1}}};
    localparam logic [BIN_W-1:0] SAT_NEG = {1'b1, {(BIN_W-1){1'b0}}};

    // reverse double-dabble correction: a digit that picked up the 8-weight
    // bit from its upper neighbour really holds 5, so take 3 off
    localparam logic [3:0] ADJ_THR = 4'd8;
    localparam logic [3:0] ADJ_SUB = 4'd3;

    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_e;

    function automatic logic digit_bad(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd2bin_if.sv
// bcd2bin_if: request/result bundle for bcd2bin.
//   master: drives bcd_vld/bcd, observes busy and the result.
//   slave : the converter; samples the request, drives busy, bin_vld, bin, ovf, err.
interface bcd2bin_if;
    import bcd2bin_pkg::*;

    logic             bcd_vld;
    logic [BCD_W-1:0] bcd;
    logic             busy;
    logic             bin_vld;
    logic [BIN_W-1:0] bin;
    logic             ovf;
    logic             err;

    modport master (output bcd_vld, bcd, input busy, bin_vld, bin, ovf, err);
    modport slave  (input bcd_vld, bcd, output busy, bin_vld, bin, ovf, err);

endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: one BCD digit correction cell for the reverse double-dabble
// step; subtracts 3 when the digit is 8 or more.
//   d_i : digit after the right shift
//   d_o : corrected digit
module bcd_digit_adj
    import bcd2bin_pkg::*;
(
    input  logic [3:0] d_i,
    output logic [3:0] d_o
);

    assign d_o = (d_i >= ADJ_THR) ? d_i - ADJ_SUB : d_i;

endmodule

// File: rtl/bcd2bin.sv
// bcd2bin: iterative sign-magnitude BCD -> two's-complement converter.
// One right shift of {bcd_sr, mag} per clock for MAG_W clocks, then a
// single finish cycle that produces bin/ovf/err with a one-cycle bin_vld.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : bcd2bin_if.slave (bcd_vld, bcd in; busy, bin_vld, bin, ovf, err out)
// Build macro: BCD2BIN_SAT_EN -- clamp bin to the nearest limit on overflow
// instead of wrapping.
module bcd2bin
    import bcd2bin_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    bcd2bin_if.slave  bus
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic [4*ND-1:0]     sr_q, sr_d;
    logic [MAG_W-1:0]    mag_q, mag_d;
    logic [ND-1:0]       inv_q, inv_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;
    logic                vld_q, vld_d;

    // shifted pair; the BCD LSB falls into the magnitude MSB
    logic [4*ND+MAG_W-1:0] sh;
    logic [4*ND-1:0]       sh_bcd, sr_adj;
    logic [MAG_W-1:0]      sh_mag, neg_mag;
    logic [ND-1:0]         in_bad;
    logic                  ovf_c;
    logic [BIN_W-1:0]      bin_wrap;

    assign sh     = {1'b0, sr_q, mag_q[MAG_W-1:1]};
    assign sh_bcd = sh[4*ND+MAG_W-1:MAG_W];
    assign sh_mag = sh[MAG_W-1:0];

    for (genvar g = 0; g < ND; g++) begin : g_dig
        bcd_digit_adj u_adj (
            .d_i (sh_bcd[4*g +: 4]),
            .d_o (sr_adj[4*g +: 4])
        );
        assign in_bad[g] = digit_bad(bus.bcd[4*g +: 4]);
    end

    assign neg_mag  = -mag_q;
    assign bin_wrap = sign_q ? neg_mag[BIN_W-1:0] : mag_q[BIN_W-1:0];
    // -1024 still fits, so the negative limit is one larger
    assign ovf_c    = sign_q ? (mag_q > BIN_MAX_NEG) : (mag_q > BIN_MAX_POS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        sr_d    = sr_q;
        mag_d   = mag_q;
        inv_d   = inv_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        vld_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.bcd_vld) begin
                    sign_d  = bus.bcd[BCD_W-1];
                    sr_d    = bus.bcd[4*ND-1:0];
                    inv_d   = in_bad;
                    mag_d   = '0;
                    cnt_d   = CNT_W'(MAG_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_adj;
                mag_d = sh_mag;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIN;
            end
            FIN: begin
                vld_d   = 1'b1;
                state_d = IDLE;
                if (|inv_q) begin
                    err_d = 1'b1;
                    ovf_d = 1'b0;
                    bin_d = '0;
                end else begin
                    err_d = 1'b0;
                    ovf_d = ovf_c;
`ifdef BCD2BIN_SAT_EN
                    bin_d = ovf_c ? (sign_q ? SAT_NEG : SAT_POS) : bin_wrap;
`else
                    bin_d = bin_wrap;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            sr_q    <= '0;
            mag_q   <= '0;
            inv_q   <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            sr_q    <= sr_d;
            mag_q   <= mag_d;
            inv_q   <= inv_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.bin_vld = vld_q;
    assign bus.bin     = bin_q;
    assign bus.ovf     = ovf_q;
    assign bus.err     = err_q;

endmodule
